// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter. Scanout reads take priority over queued CPU writes.
// Optional VRAM_ARB_STATS_EN adds the stall_cnt back-pressure counter port.
module vram_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PIX_SHIFT  = 3,
    parameter int LINE_WORDS = 100
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              blank_n,
    input  logic [10:0]       next_pixel_h,
    input  logic [10:0]       next_pixel_v,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [10:0] LAST_COL = 11'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] pix_hold_q, pix_hold_d;
    logic blank_d1_q, blank_d1_d;
    logic pix_valid_q, pix_valid_d;
    logic full, empty, push, pop;
    logic [10:0] blk_h, blk_v, blk_h_c;
    logic [ADDR_W-1:0] scan_addr;

    // Next-state, FIFO bookkeeping and registered VRAM port values
    always_comb begin
        blk_v   = next_pixel_v >> PIX_SHIFT;
        blk_h   = next_pixel_h >> PIX_SHIFT;
        blk_h_c = (blk_h > LAST_COL) ? LAST_COL : blk_h;
        scan_addr = ADDR_W'(blk_v) * ADDR_W'(LINE_WORDS) + ADDR_W'(blk_h_c);

        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        push  = cpu_wr_req && !full;

        if (blank_n)     state_d = SCAN;
        else if (!empty) state_d = WRITE;
        else             state_d = IDLE;
        pop = (state_d == WRITE);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (state_d == SCAN) begin
            ram_addr_d = scan_addr;
        end else if (state_d == WRITE) begin
            ram_addr_d  = fifo_addr[rd_ptr_q];
            ram_wdata_d = fifo_data[rd_ptr_q];
        end

        blank_d1_d  = blank_n;
        pix_valid_d = blank_d1_q;
        pix_hold_d  = pix_valid_q ? ram_rdata : pix_hold_q;
    end

    // FSM, FIFO pointers and output registers; reset discards queued writes
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            blank_d1_q  <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            blank_d1_q  <= blank_d1_d;
            pix_valid_q <= pix_valid_d;
            pix_hold_q  <= pix_hold_d;
        end
    end

    // FIFO storage; emptiness is tracked by count, so no reset needed
    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= cpu_wr_addr;
            fifo_data[wr_ptr_q] <= cpu_wr_data;
        end
    end

    assign cpu_wr_ready = !full;
    assign ram_we       = (state_q == WRITE);
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_valid_q ? ram_rdata : pix_hold_q;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles the CPU is held off by a full FIFO
    always_comb begin
        stall_d = stall_q;
        if (cpu_wr_req && full && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    // Stall counter register
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 13, VRAM word-address width.
REQ-002 Parameter: DATA_W, 8, VRAM data width.
REQ-003 Parameter: FIFO_DEPTH, 4, CPU write FIFO entries; power of two, 2 or more.
REQ-004 Parameter: PIX_SHIFT, 3, log2 of the pixel block size (8x8 pixels per VRAM word).
REQ-005 Parameter: LINE_WORDS, 100, VRAM words per block row.
REQ-006 Port: vga_clk  in  1  pixel clock; all logic is on its rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-high.
REQ-008 Port: blank_n  in  1  active-video flag from the sync generator.
REQ-009 Port: next_pixel_h  in  11  horizontal pixel index from the sync generator.
REQ-010 Port: next_pixel_v  in  11  vertical pixel index from the sync generator.
REQ-011 Port: cpu_wr_req  in  1  CPU write request.
REQ-012 Port: cpu_wr_addr  in  ADDR_W  CPU write address.
REQ-013 Port: cpu_wr_data  in  DATA_W  CPU write data.
REQ-014 Port: cpu_wr_ready  out  1  FIFO not full; a write is accepted when cpu_wr_req && cpu_wr_ready at a clock edge.
REQ-015 Port: ram_addr  out  ADDR_W  single-port VRAM address, registered.
REQ-016 Port: ram_wdata  out  DATA_W  VRAM write data, registered.
REQ-017 Port: ram_we  out  1  VRAM write enable, registered.
REQ-018 Port: ram_rdata  in  DATA_W  VRAM read data; synchronous RAM with 1-cycle read latency.
REQ-019 Port: pix_data  out  DATA_W  fetched block value for the pixel pipeline.
REQ-020 Port: pix_valid  out  1  pix_data is valid.
REQ-021 Port: stall_cnt  out  16  CPU back-pressure cycle count; present only with VRAM_ARB_STATS_EN.

Function
REQ-022 A state register SHALL take exactly one state per cycle: IDLE, SCAN or WRITE.
- Next state is SCAN if blank_n=1.
- Otherwise next state is WRITE if the FIFO is non-empty.
- Otherwise next state is IDLE.
REQ-023 In SCAN, the arbiter SHALL drive the following in the same registered update: ram_we=0, ram_addr=((next_pixel_v>>PIX_SHIFT)*LINE_WORDS + min(next_pixel_h>>PIX_SHIFT, LINE_WORDS-1)), truncated to ADDR_W.
REQ-024 In WRITE, the arbiter SHALL drive ram_we=1 with ram_addr/ram_wdata set to the FIFO head entry, and pop that entry in the same cycle.
REQ-025 In IDLE, the arbiter SHALL drive ram_we=0; ram_addr and ram_wdata hold their previous values.
REQ-026 CPU writes SHALL never reach VRAM while blank_n=1; scanout has absolute priority.
REQ-027 pix_valid SHALL equal blank_n delayed by exactly 2 cycles; pix_data SHALL capture ram_rdata on those cycles and hold otherwise.
REQ-028 The FIFO SHALL preserve write order; cpu_wr_ready=0 exactly when the count equals FIFO_DEPTH.
REQ-029 A push and a pop in the same cycle SHALL leave the count unchanged; a full FIFO accepts no push, even when a pop occurs in that cycle.
REQ-030 A push into an empty FIFO SHALL be visible on ram_we no earlier than 2 edges after acceptance.
REQ-031 next_pixel_h=800 (generator wrap value) SHALL clamp to block column LINE_WORDS-1 and never produce an address in the next row.

Reset
REQ-032 On reset, the block SHALL asynchronously set: state=IDLE, FIFO empty, ram_we=0, ram_addr=0, ram_wdata=0, pix_data=0, pix_valid=0, cpu_wr_ready=1, stall_cnt=0.
REQ-033 Reset asserted mid-WRITE SHALL drop ram_we immediately and discard all queued writes; after release the first edge follows REQ-022.

Configuration
REQ-034 With macro VRAM_ARB_STATS_EN defined, stall_cnt SHALL increment each cycle cpu_wr_req=1 && cpu_wr_ready=0, saturate at 0xFFFF, and clear only on reset.
REQ-035 Without VRAM_ARB_STATS_EN, the stall_cnt port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Scenario: blank_n=1, next_pixel_v=17, next_pixel_h=42 -> ram_addr=205 after 1 edge; pix_valid=1 with pix_data=RAM[205] after 2 edges.
REQ-037 Scenario: 5 back-to-back CPU writes during active video -> 4 accepted, cpu_wr_ready=0 on the 5th, ram_we stays 0 until blank_n=0.
REQ-038 Scenario: blank_n falls with 4 queued writes (A0..A3) -> ram_we=1 for 4 consecutive cycles in order A0..A3, then IDLE, cpu_wr_ready=1.
REQ-039 Scenario: next_pixel_h=800, next_pixel_v=0 in SCAN -> ram_addr=99.
REQ-040 Scenario: reset pulse during the 2nd of 4 writes -> ram_we=0 asynchronously, the remaining writes are never issued, FIFO empty.
REQ-041 Scenario: VRAM_ARB_STATS_EN defined, cpu_wr_req held against a full FIFO for 70000 cycles -> stall_cnt=0xFFFF.
